// File: rtl/freq_meter.sv
// ============================================================================
// freq_meter : counts rising edges of an asynchronous input per gate window
// Optional macro FREQ_METER_SYNC3_EN selects a 3-flop input synchronizer.
// Rev 1.0
// ============================================================================
`default_nettype none

module freq_meter #(
  parameter int unsigned CLOCK_HZ    = 50_000_000,
  parameter int unsigned GATE_CYCLES = CLOCK_HZ,
  parameter int unsigned WIDTH       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sig,
  input  logic             i_enable,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_count,
  output logic             o_valid,
  output logic             o_overflow,
  output logic             o_overrun
);

`ifdef FREQ_METER_SYNC3_EN
  localparam int unsigned SYNC_STAGES = 3;
`else
  localparam int unsigned SYNC_STAGES = 2;
`endif

  localparam logic [31:0]      GATE_LAST = 32'(GATE_CYCLES - 1);
  localparam logic [WIDTH-1:0] EDGE_MAX  = '1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [31:0]            gate_q, gate_d;
  logic [WIDTH-1:0]       edge_q, edge_d;
  logic                   sat_q, sat_d;
  logic [WIDTH-1:0]       count_q, count_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic                   overrun_q, overrun_d;

  logic                   rise;
  logic                   active;
  logic                   win_end;
  logic                   edge_full;
  logic [WIDTH-1:0]       edge_next;
  logic                   sat_next;

  assign rise      = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign active    = (state_q == GATE) && i_enable;
  assign win_end   = active && (gate_q == GATE_LAST);
  assign edge_full = (edge_q == EDGE_MAX);
  // Saturation means an edge was lost: a rise arrived with the counter already full.
  assign edge_next = (rise && !edge_full) ? edge_q + 1'b1 : edge_q;
  assign sat_next  = sat_q | (rise & edge_full);

  always_comb begin
    state_d   = state_q;
    gate_d    = '0;
    edge_d    = '0;
    sat_d     = 1'b0;
    count_d   = count_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    overrun_d = overrun_q;

    case (state_q)
      IDLE: if (i_enable)  state_d = GATE;
      GATE: if (!i_enable) state_d = IDLE;
    endcase

    if (active && !win_end) begin
      gate_d = gate_q + 32'd1;
      edge_d = edge_next;
      sat_d  = sat_next;
    end

    // A load wins over a consume, so a same-cycle handshake keeps o_valid high.
    if (win_end) begin
      count_d = edge_next;
      ovf_d   = sat_next;
      valid_d = 1'b1;
      if (valid_q && !i_ready) overrun_d = 1'b1;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      hist_q    <= 1'b0;
      gate_q    <= '0;
      edge_q    <= '0;
      sat_q     <= 1'b0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], i_sig};
      hist_q    <= sync_q[SYNC_STAGES-1];
      gate_q    <= gate_d;
      edge_q    <= edge_d;
      sat_q     <= sat_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_count    = count_q;
  assign o_valid    = valid_q;
  assign o_overflow = ovf_q;
  assign o_overrun  = overrun_q;

endmodule

`default_nettype wire

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 50_000_000, meaning the i_clk frequency in Hz (documentation and gate default only).
REQ-002 SHALL have parameter GATE_CYCLES, default CLOCK_HZ, meaning the measurement window length in i_clk cycles (legal range 2..2^32-1).
REQ-003 SHALL have parameter WIDTH, default 32, meaning the width of the edge counter and result.
REQ-004 SHALL have port i_clk  input  1  the single system clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_sig  input  1  measured signal, asynchronous to i_clk, e.g. a divider MSB.
REQ-007 SHALL have port i_enable  input  1  measurement enable, level-sensitive.
REQ-008 SHALL have port i_ready  input  1  consumer accepts the current result.
REQ-009 SHALL have port o_count  output  WIDTH  rising edges of i_sig counted in the last completed window.
REQ-010 SHALL have port o_valid  output  1  o_count holds an unconsumed result.
REQ-011 SHALL have port o_overflow  output  1  o_count saturated during its window.
REQ-012 SHALL have port o_overrun  output  1  sticky; a result was overwritten before being consumed.

Function
REQ-013 SHALL pass i_sig through a 2-flop synchronizer, then one history flop; rise = sync AND NOT history.
REQ-014 SHALL implement FSM states IDLE and GATE; IDLE->GATE when i_enable=1; GATE->IDLE when i_enable=0; any state->IDLE on reset.
REQ-015 SHALL in IDLE hold the gate counter and edge counter at 0; a window discarded by i_enable falling mid-window produces no result.
REQ-016 SHALL in GATE increment the gate counter each cycle from 0 to GATE_CYCLES-1, then wrap to 0; the wrap cycle is window end.
REQ-017 SHALL increment the edge counter on each rise cycle, saturating at 2^WIDTH-1 and setting an internal saturated flag.
REQ-018 SHALL at window end load o_count with edge counter plus a rise in that same cycle (saturating), load o_overflow from saturated flag (or that final increment saturating), clear the edge counter and saturated flag, and start the next window the following cycle with no gap.
REQ-019 SHALL set o_valid one cycle after window end (registered with o_count).
REQ-020 SHALL clear o_valid on a cycle with o_valid=1 and i_ready=1, unless a new result loads in that same cycle, in which case o_valid stays 1 with the new data and o_overrun is not set.
REQ-021 SHALL set o_overrun when a result loads while o_valid=1 and i_ready=0; o_overrun clears only on reset.
REQ-022 SHALL keep o_count, o_overflow stable while o_valid=1 except on a new result load.
REQ-023 SHALL count edge-to-result latency: a rise of i_sig is counted no later than 3 i_clk cycles after it (sync+edge detect).

Reset
REQ-024 SHALL, on i_rst_n=0, asynchronously clear FSM to IDLE, all counters, synchronizer and history flops, o_count=0, o_valid=0, o_overflow=0, o_overrun=0.
REQ-025 SHALL, on reset release mid-window, start from IDLE; first result appears only after a full GATE_CYCLES window.

Configuration
REQ-026 SHALL, with macro FREQ_METER_SYNC3_EN defined, use a 3-flop synchronizer (edge latency 4 cycles); without it, a 2-flop synchronizer (latency 3 cycles); counts per window identical for steady signals.

Verification
REQ-027 SHALL verify GATE_CYCLES=100, i_sig square wave period 10 cycles, i_ready=1 -> every result o_count=10, o_overflow=0.
REQ-028 SHALL verify WIDTH=4, GATE_CYCLES=100, i_sig period 4 -> o_count=15, o_overflow=1; next window after i_sig stops -> o_count=0, o_overflow=0.
REQ-029 SHALL verify i_ready=0 for two windows -> o_valid=1 after first, o_overrun=1 after second, o_count from second window.
REQ-030 SHALL verify i_enable dropped at gate cycle 50 of 100, raised again -> no o_valid until 100 cycles after re-enable.
REQ-031 SHALL verify i_rst_n asserted mid-window with o_valid=1 -> all outputs 0 immediately, without a clock edge.
REQ-032 SHALL verify i_ready=1 in the same cycle a new result loads -> o_valid stays 1, o_overrun stays 0.
